// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 1 start bit, DBIT data bits LSB-first, 1 stop bit, no parity.
// A stop bit sampled low raises FRAME_ERR and then waits for the line to return high.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            RX,
  input  logic            TICK,
  output logic [DBIT-1:0] DOUT,
  output logic            RX_DONE,
  output logic            FRAME_ERR
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   sreg_q, sreg_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              rx_meta_q, rx_s_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sreg_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sreg_d  = sreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Start edge is detected at CLK resolution, independent of TICK.
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (TICK) begin
          if (s_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (TICK) begin
          if (s_q == 4'd15) begin
            sreg_d = {rx_s_q, sreg_q[DBIT-1:1]};
            s_d    = '0;
            if (n_q == NW'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (TICK) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            s_d = '0;
            if (rx_s_q) begin
              dout_d  = sreg_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BRK;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      BRK: begin
        // Hold off until the line returns high so a break is not decoded as 0x00 frames.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign DOUT      = dout_q;
  assign RX_DONE   = done_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: TICK every 4 CLK (64 CLK per bit), frames driven on RX and
// checked against a frame-level model of the expected RX_DONE/FRAME_ERR events.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       RX    = 1'b1;
  logic       TICK  = 1'b0;
  logic [7:0] DOUT;
  logic       RX_DONE;
  logic       FRAME_ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stop_mid = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] dout;
    int         cyc;
  } ev_t;
  ev_t ev_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         gap_bits;
    logic       exp_err;
    logic [7:0] exp_dout;
  } vec_t;
  vec_t vecs[5];

  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;
  logic [7:0] dout_prev = 8'h00;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .CLK(CLK), .RESET(RESET), .RX(RX), .TICK(TICK),
    .DOUT(DOUT), .RX_DONE(RX_DONE), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge CLK);
      TICK = (tc == 3);
      tc = (tc + 1) % 4;
    end
  end

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Event monitor: records every strobe and checks pulse exclusivity and DOUT stability.
  always @(negedge CLK) begin
    if (RX_DONE || FRAME_ERR) begin
      ev_q.push_back('{FRAME_ERR, DOUT, cyc});
      chk("pulse_excl", int'(RX_DONE & FRAME_ERR), 0);
      chk("pulse_gap", int'(prev_pulse), 0);
    end
    if (DOUT !== dout_prev)
      chk("dout_hold", int'(RX_DONE || !RESET), 1);
    prev_pulse <= RX_DONE | FRAME_ERR;
    dout_prev  <= DOUT;
  end

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (BIT_CLK) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int gap_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    stop_mid = cyc + BIT_CLK / 2;
    drive_bit(stop_bit);
    if (gap_bits > 0) begin
      RX = 1'b1;
      repeat (gap_bits * BIT_CLK) @(negedge CLK);
    end
  endtask

  task automatic check_frame(string name, logic exp_err, logic [7:0] exp_dout);
    ev_t ev;
    int  delta;
    chk({name, "_count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      ev = ev_q.pop_front();
      delta = ev.cyc - stop_mid;
      chk({name, "_err"}, int'(ev.is_err), int'(exp_err));
      chk({name, "_dout"}, int'(ev.dout), int'(exp_dout));
      chk({name, "_latency"}, int'(delta >= 0 && delta <= 40), 1);
      $display("frame %s: err=%0d dout=0x%02h latency=%0d", name, ev.is_err, ev.dout, delta);
    end
    ev_q.delete();
  endtask

  // Frame-level reference: good stop bit delivers the byte, bad stop bit keeps the last good byte.
  task automatic model_and_check(string name, logic [7:0] data, logic stop_bit);
    logic [7:0] exp_dout;
    exp_dout = stop_bit ? data : last_good;
    if (stop_bit) last_good = data;
    check_frame(name, !stop_bit, exp_dout);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, 1, 1'b0, 8'h3C};
    vecs[4] = '{8'h55, 1'b0, 2, 1'b1, 8'h3C};

    // Reset with RX toggling.
    #1 RESET = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      RX = 1'($urandom_range(0, 1));
    end
    chk("rst_dout", int'(DOUT), 0);
    chk("rst_done", int'(RX_DONE), 0);
    chk("rst_ferr", int'(FRAME_ERR), 0);
    RX = 1'b1;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    repeat (100) @(negedge CLK);
    chk("idle_dout", int'(DOUT), 0);
    chk("idle_events", ev_q.size(), 0);
    $display("reset: DOUT=0x%02h RX_DONE=%0d FRAME_ERR=%0d", DOUT, RX_DONE, FRAME_ERR);
    ev_q.delete();

    // Table vectors: single byte, back-to-back, framing error with short low hold.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].gap_bits);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_dout);
    end
    last_good = 8'h3C;

    // Glitch: 3 tick periods low.
    RX = 1'b0;
    repeat (12) @(negedge CLK);
    RX = 1'b1;
    repeat (2 * BIT_CLK) @(negedge CLK);
    chk("glitch_events", ev_q.size(), 0);
    $display("glitch: events=%0d", ev_q.size());
    ev_q.delete();
    send_frame(8'h5A, 1'b1, 1);
    model_and_check("after_glitch", 8'h5A, 1'b1);

    // Framing error followed by a 40-bit break.
    send_frame(8'h81, 1'b0, 0);
    model_and_check("break_ferr", 8'h81, 1'b0);
    repeat (40 * BIT_CLK) @(negedge CLK);
    chk("break_quiet", ev_q.size(), 0);
    chk("break_dout", int'(DOUT), 8'h5A);
    $display("break: events=%0d DOUT=0x%02h", ev_q.size(), DOUT);
    ev_q.delete();
    RX = 1'b1;
    repeat (BIT_CLK) @(negedge CLK);
    send_frame(8'h81, 1'b1, 1);
    model_and_check("after_break", 8'h81, 1'b1);

    // Reset during data bit 4 of 0xC3, held through the rest of the frame.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
    RX = 1'b0;
    repeat (10) @(negedge CLK);
    RESET = 1'b0;
    repeat (BIT_CLK - 10) @(negedge CLK);
    for (int i = 5; i < 8; i++) drive_bit(1'(8'hC3 >> i));
    drive_bit(1'b1);
    chk("midrst_dout", int'(DOUT), 0);
    chk("midrst_events", ev_q.size(), 0);
    $display("mid-frame reset: DOUT=0x%02h events=%0d", DOUT, ev_q.size());
    ev_q.delete();
    RESET = 1'b1;
    last_good = 8'h00;
    repeat (BIT_CLK) @(negedge CLK);
    send_frame(8'hC3, 1'b1, 1);
    model_and_check("after_midrst", 8'hC3, 1'b1);

    // Randomized frames.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic       sb;
      int         gap;
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 4) != 0);
      gap = sb ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      send_frame(d, sb, gap);
      model_and_check($sformatf("rand%0d", i), d, sb);
    end

    repeat (2 * BIT_CLK) @(negedge CLK);
    chk("final_quiet", ev_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
